// File: rtl/gate_share_pkg.sv
// Shared definitions for the gate_share_sched scheduler family:
// FSM state encoding and default configuration constants.
package gate_share_pkg;

   // Default number of requesters and settle interval (cycles).
   localparam int unsigned DEF_N      = 4;
   localparam int unsigned DEF_SETTLE = 2;

   // Scheduler FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SETTLE  = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;

endpackage

// File: rtl/gate_share_sched_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set
// request bit at or above ptr, wrapping around to bit 0.
module rr_pick
   import gate_share_pkg::*;
#(
   parameter int unsigned N   = DEF_N,
   parameter int unsigned IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           valid,
   output logic [IDW-1:0] id
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned k;
      valid = 1'b0;
      id    = '0;
      k     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (!valid && req[k[IDW-1:0]]) begin
            valid = 1'b1;
            id    = k[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/gate_share_sched.sv
// gate_share_sched: time-shares one external gate_and cell among N
// requesters. A round-robin winner's operands are driven onto the cell
// for SETTLE cycles, the cell output is sampled, and the result is
// returned with a one-cycle gnt/rsp_valid pulse.
// Optional feature: define GATE_SHARE_SELFCHECK_EN to compare each sample
// against the driven a&b and raise a sticky err on mismatch (incl. x/z).
module gate_share_sched
   import gate_share_pkg::*;
#(
   parameter int unsigned N      = DEF_N,
   parameter int unsigned SETTLE = DEF_SETTLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         a,
   input  logic [N-1:0]         b,
   output logic [N-1:0]         gnt,
   output logic                 rsp_valid,
   output logic [$clog2(N)-1:0] rsp_id,
   output logic                 rsp_data,
   output logic                 busy,
   output logic                 gate_inp1,
   output logic                 gate_inp2,
   input  logic                 gate_out,
   output logic                 err
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned CW  = $clog2(SETTLE + 1);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] ptr;
   logic           pick_valid;
   logic [IDW-1:0] pick_id;
   logic           last_settle;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .id    (pick_id)
   );

   assign busy        = (state != ST_IDLE);
   assign last_settle = (state == ST_SETTLE) && (cnt == CW'(1));

   // Scheduler FSM. gate_inp1/2 double as the latched operand pair: they
   // are loaded at selection, held through SETTLE and cleared on capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         id_q      <= '0;
         ptr       <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= 1'b0;
         gate_inp1 <= 1'b0;
         gate_inp2 <= 1'b0;
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  id_q      <= pick_id;
                  gate_inp1 <= a[pick_id];
                  gate_inp2 <= b[pick_id];
                  cnt       <= CW'(SETTLE);
                  state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               cnt <= cnt - CW'(1);
               if (last_settle) begin
                  rsp_data  <= gate_out;
                  rsp_valid <= 1'b1;
                  gnt       <= N'(1) << id_q;
                  rsp_id    <= id_q;
                  gate_inp1 <= 1'b0;
                  gate_inp2 <= 1'b0;
                  state     <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               ptr   <= (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef GATE_SHARE_SELFCHECK_EN
   // Sticky self-check. The compare is evaluated on the same edge that
   // captures the sample, so err is already high during the CAPTURE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (last_settle && (gate_out !== (gate_inp1 & gate_inp2))) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gate_share_sched.sv
// Self-checking bench for gate_share_sched (N=4, SETTLE=2). A transaction
// level model predicts, per cycle, which requester is being served and
// what every output must show; directed scenarios are followed by a
// randomized request phase.
module tb_gate_share_sched;

   localparam int N      = 4;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] a   = '0;
   logic [3:0] b   = '0;
   logic [3:0] gnt;
   logic       rsp_valid;
   logic [1:0] rsp_id;
   logic       rsp_data;
   logic       busy;
   logic       gate_inp1;
   logic       gate_inp2;
   logic       gate_out;
   logic       err;

   // Behavioural gate_and cell with a fault override on its output.
   logic fault_en  = 1'b0;
   logic fault_val = 1'b0;
   assign gate_out = fault_en ? fault_val : (gate_inp1 & gate_inp2);

   gate_share_sched #(
      .N      (N),
      .SETTLE (SETTLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a         (a),
      .b         (b),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .gate_inp1 (gate_inp1),
      .gate_inp2 (gate_inp2),
      .gate_out  (gate_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int sel_cyc = -1000;
   int rst_cyc = -1000;
   int m_id    = 0;
   int ptr_m   = 0;
   logic m_a = 1'b0, m_b = 1'b0, m_data = 1'b0, err_m = 1'b0;
   int dut_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Compare every output for the current cycle against the model.
   task automatic check_outputs();
      logic v, drv, bsy;
      v   = (cyc == sel_cyc + SETTLE + 1);
      drv = (cyc >= sel_cyc + 1) && (cyc <= sel_cyc + SETTLE);
      bsy = (cyc >= sel_cyc + 1) && (cyc <= sel_cyc + SETTLE + 1);
`ifdef GATE_SHARE_SELFCHECK_EN
      if (v && (m_data !== (m_a & m_b))) err_m = 1'b1;
`endif
      chk("rsp_valid", 32'(rsp_valid), 32'(v));
      chk("gnt", 32'(gnt), v ? (32'd1 << m_id) : 32'd0);
      chk("busy", 32'(busy), 32'(bsy));
      chk("gate_inp1", 32'(gate_inp1), drv ? 32'(m_a) : 32'd0);
      chk("gate_inp2", 32'(gate_inp2), drv ? 32'(m_b) : 32'd0);
      chk("err", 32'(err), 32'(err_m));
      if (v) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
      end
      if (cyc == rst_cyc + 1) begin
         chk("rst_rsp_id", 32'(rsp_id), 32'd0);
         chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      end
      if (rsp_valid === 1'b1) dut_log.push_back(int'(rsp_id));
   endtask

   // Model: on a free cycle with requests pending, serve the first
   // requester at or after the rotating pointer.
   task automatic model_update();
      logic found;
      found = 1'b0;
      if (rst) begin
         sel_cyc = -1000;
         ptr_m   = 0;
         err_m   = 1'b0;
         rst_cyc = cyc;
      end else if (cyc >= sel_cyc + SETTLE + 2 && req != 4'b0) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr_m + k) % N;
            if (!found && req[idx]) begin
               found = 1'b1;
               m_id  = idx;
               m_a   = a[idx];
               m_b   = b[idx];
            end
         end
         if (found) begin
            sel_cyc = cyc;
            ptr_m   = (m_id + 1) % N;
            m_data  = fault_en ? fault_val : (m_a & m_b);
         end
      end
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ra, input logic [3:0] rb);
      @(negedge clk);
      check_outputs();
      rst = r;
      req = rq;
      a   = ra;
      b   = rb;
      model_update();
      cyc++;
   endtask

   initial begin
      logic [3:0] rq, ra, rb, ca, cb;
      int g, inf;
      int exp_cont[5];
      int exp_late[3];
      exp_cont = '{0, 1, 2, 3, 0};
      exp_late = '{2, 3, 1};

      // Reset
      step(1'b1, 4'h0, 4'h0, 4'h0);
      step(1'b0, 4'h0, 4'h0, 4'h0);

      // Single request on requester 0 with a=b=1
      repeat (3) step(1'b0, 4'b0001, 4'b0001, 4'b0001);
      repeat (2) step(1'b0, 4'h0, 4'h0, 4'h0);

      // Truth table on requester 2
      for (int i = 0; i < 4; i++) begin
         logic [1:0] tv;
         tv = 2'(i);
         ca = {1'b0, tv[1], 2'b00};
         cb = {1'b0, tv[0], 2'b00};
         repeat (3) step(1'b0, 4'b0100, ca, cb);
         repeat (2) step(1'b0, 4'h0, 4'h0, 4'h0);
      end

      // Full contention from ptr=0
      step(1'b1, 4'h0, 4'h0, 4'h0);
      dut_log.delete();
      ca = 4'($urandom);
      cb = 4'($urandom);
      repeat (20) step(1'b0, 4'hF, ca, cb);
      chk("cont_count", 32'(dut_log.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++)
         chk("cont_order", (k < dut_log.size()) ? 32'(dut_log[k]) : 32'd99, 32'(exp_cont[k]));

      // Late request on 1 while serving 2
      step(1'b1, 4'h0, 4'h0, 4'h0);
      dut_log.delete();
      step(1'b0, 4'b1100, ca, cb);
      repeat (12) step(1'b0, 4'b1110, ca, cb);
      chk("late_count", 32'(dut_log.size() >= 3), 32'd1);
      for (int k = 0; k < 3; k++)
         chk("late_order", (k < dut_log.size()) ? 32'(dut_log[k]) : 32'd99, 32'(exp_late[k]));

      // Operands and request change after selection
      step(1'b1, 4'h0, 4'h0, 4'h0);
      step(1'b0, 4'b0001, 4'b0001, 4'b0001);
      step(1'b0, 4'b0000, 4'b0000, 4'b0001);
      repeat (4) step(1'b0, 4'h0, 4'h0, 4'h0);

      // Reset in the second SETTLE cycle, then next grant to requester 0
      step(1'b1, 4'h0, 4'h0, 4'h0);
      step(1'b0, 4'b0001, 4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0001, 4'b0001);
      dut_log.delete();
      step(1'b1, 4'b0001, 4'b0001, 4'b0001);
      step(1'b0, 4'b1001, 4'b1001, 4'b0001);
      repeat (4) step(1'b0, 4'b1001, 4'b1001, 4'b0001);
      chk("post_rst_first", (dut_log.size() > 0) ? 32'(dut_log[0]) : 32'd99, 32'd0);

      // Stuck-at-0 cell output with a=b=1 on requester 1
      step(1'b1, 4'h0, 4'h0, 4'h0);
      fault_en  = 1'b1;
      fault_val = 1'b0;
      repeat (3) step(1'b0, 4'b0010, 4'b0010, 4'b0010);
      repeat (4) step(1'b0, 4'h0, 4'h0, 4'h0);
`ifdef GATE_SHARE_SELFCHECK_EN
      chk("err_sticky", 32'(err), 32'd1);
`else
      chk("err_tied", 32'(err), 32'd0);
`endif
      fault_en = 1'b0;
      step(1'b1, 4'h0, 4'h0, 4'h0);
      repeat (2) step(1'b0, 4'h0, 4'h0, 4'h0);

      // Randomized requests; a requester holds req/operands until served
      rq = '0;
      ra = '0;
      rb = '0;
      repeat (500) begin
         g   = (cyc == sel_cyc + SETTLE + 1) ? m_id : -1;
         inf = (cyc >= sel_cyc + 1 && cyc <= sel_cyc + SETTLE) ? m_id : -1;
         for (int i = 0; i < N; i++) begin
            if (i == g) begin
               rq[i] = 1'($urandom_range(0, 1));
               ra[i] = 1'($urandom_range(0, 1));
               rb[i] = 1'($urandom_range(0, 1));
            end else if (i == inf) begin
               if ($urandom_range(0, 3) == 0) rq[i] = 1'b0;
               ra[i] = 1'($urandom_range(0, 1));
               rb[i] = 1'($urandom_range(0, 1));
            end else if (!rq[i]) begin
               rq[i] = ($urandom_range(0, 2) == 0);
               ra[i] = 1'($urandom_range(0, 1));
               rb[i] = 1'($urandom_range(0, 1));
            end
         end
         if ($urandom_range(0, 150) == 0) step(1'b1, rq, ra, rb);
         else step(1'b0, rq, ra, rb);
      end
      repeat (5) step(1'b0, 4'h0, 4'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
